// File: rtl/forward_hazard_if.sv
// Bundle between the ID/EX pipeline control and the forwarding/hazard unit:
// ID-stage decode fields in, stall request and registered EX mux selects out.
interface forward_hazard_if #(
  parameter int REG_AW = 5,
  parameter int CNT_W  = 16
);
  logic              id_valid;
  logic [REG_AW-1:0] id_rs;
  logic [REG_AW-1:0] id_rt;
  logic              id_uses_rt;
  logic [REG_AW-1:0] id_dst;
  logic              id_reg_write;
  logic              id_mem_read;
  logic              flush;
  logic              stall;
  logic [1:0]        fwd_a_sel;
  logic [1:0]        fwd_b_sel;
  logic [CNT_W-1:0]  stall_count;

  modport master (
    output id_valid, id_rs, id_rt, id_uses_rt, id_dst, id_reg_write, id_mem_read, flush,
    input  stall, fwd_a_sel, fwd_b_sel, stall_count
  );

  modport slave (
    input  id_valid, id_rs, id_rt, id_uses_rt, id_dst, id_reg_write, id_mem_read, flush,
    output stall, fwd_a_sel, fwd_b_sel, stall_count
  );
endinterface

// File: rtl/forward_hazard_unit.sv
// EX-stage operand forwarding select generation and load-use stall detection
// for a 5-stage MIPS pipeline, with a saturating stall-cycle counter.
module forward_hazard_unit #(
  parameter int REG_AW = 5,
  parameter int CNT_W  = 16
) (
  input  logic           clk,
  input  logic           rst_n,
  forward_hazard_if.slave bus
);

  localparam logic [1:0] SEL_RF    = 2'b00;
  localparam logic [1:0] SEL_EXMEM = 2'b01;
  localparam logic [1:0] SEL_MEMWB = 2'b10;

  typedef struct packed {
    logic              valid;
    logic [REG_AW-1:0] dst;
    logic              reg_write;
    logic              mem_read;
  } stage_t;

  localparam stage_t BUBBLE = '{valid: 1'b0, dst: {REG_AW{1'b0}}, reg_write: 1'b0, mem_read: 1'b0};
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  stage_t           idex_r;
  stage_t           exmem_r;
  stage_t           memwb_r;
  logic [1:0]       fwd_a_r;
  logic [1:0]       fwd_b_r;
  logic [CNT_W-1:0] stall_cnt_r;

  logic             load_hit_s;
  logic             stall_s;
  logic             kill_s;
  stage_t           id_entry_s;
  logic [1:0]       sel_a_s;
  logic [1:0]       sel_b_s;

  // Register 0 is hardwired to zero, so an entry targeting it never produces a value.
  function automatic logic writes_reg(input stage_t e, input logic [REG_AW-1:0] r);
    return e.valid & e.reg_write & (e.dst == r) & (e.dst != {REG_AW{1'b0}});
  endfunction

  // Nearer producer (EX/MEM result next cycle) wins over the farther one.
  function automatic logic [1:0] pick_sel(input stage_t near_e, input stage_t far_e,
                                          input logic [REG_AW-1:0] r);
    logic [1:0] sel;
    if (writes_reg(near_e, r)) begin
      sel = SEL_EXMEM;
    end else if (writes_reg(far_e, r)) begin
      sel = SEL_MEMWB;
    end else begin
      sel = SEL_RF;
    end
    return sel;
  endfunction

  // Load-use detection, kill decision and next select codes for the ID instruction.
  always_comb begin
    load_hit_s = idex_r.valid & idex_r.mem_read & idex_r.reg_write
               & (idex_r.dst != {REG_AW{1'b0}})
               & ((idex_r.dst == bus.id_rs) | (bus.id_uses_rt & (idex_r.dst == bus.id_rt)));
    stall_s    = bus.id_valid & ~bus.flush & load_hit_s;
    kill_s     = bus.flush | stall_s | ~bus.id_valid;

    id_entry_s.valid     = bus.id_valid;
    id_entry_s.dst       = bus.id_dst;
    id_entry_s.reg_write = bus.id_reg_write;
    id_entry_s.mem_read  = bus.id_mem_read;

    if (kill_s) begin
      sel_a_s = SEL_RF;
      sel_b_s = SEL_RF;
    end else begin
      sel_a_s = pick_sel(idex_r, exmem_r, bus.id_rs);
      if (bus.id_uses_rt) begin
        sel_b_s = pick_sel(idex_r, exmem_r, bus.id_rt);
      end else begin
        sel_b_s = SEL_RF;
      end
    end
  end

  // Shadow pipeline of destination info; a killed ID slot enters as a bubble.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idex_r  <= BUBBLE;
      exmem_r <= BUBBLE;
      memwb_r <= BUBBLE;
    end else begin
      memwb_r <= exmem_r;
      exmem_r <= idex_r;
      if (kill_s) begin
        idex_r <= BUBBLE;
      end else begin
        idex_r <= id_entry_s;
      end
    end
  end

  // Select codes registered so they line up with the instruction now in EX.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fwd_a_r <= SEL_RF;
      fwd_b_r <= SEL_RF;
    end else begin
      fwd_a_r <= sel_a_s;
      fwd_b_r <= sel_b_s;
    end
  end

  // Saturating stall-cycle counter; holds at all-ones instead of wrapping.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt_r <= {CNT_W{1'b0}};
    end else if (stall_s && (stall_cnt_r != CNT_MAX)) begin
      stall_cnt_r <= stall_cnt_r + CNT_ONE;
    end else begin
      stall_cnt_r <= stall_cnt_r;
    end
  end

  // MEM/WB shadow is kept for visibility; WB-to-ID bypass is the register file's job.
  logic memwb_unused_s;
  assign memwb_unused_s = ^memwb_r;

  assign bus.stall       = stall_s;
  assign bus.fwd_a_sel   = fwd_a_r;
  assign bus.fwd_b_sel   = fwd_b_r;
  assign bus.stall_count = stall_cnt_r;

endmodule

// File: tb/tb_forward_hazard_unit.sv
// Directed-vector bench for forward_hazard_unit with hand-computed expectations.
module tb_forward_hazard_unit;

  localparam int REG_AW = 5;
  localparam int CNT_W  = 4;

  logic clk;
  logic rst_n;
  int   vec_cnt;
  int   err_cnt;

  forward_hazard_if #(.REG_AW(REG_AW), .CNT_W(CNT_W)) bus ();

  forward_hazard_unit #(.REG_AW(REG_AW), .CNT_W(CNT_W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vec_cnt++;
    if (got !== exp) begin
      err_cnt++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic issue(input logic v, input logic [4:0] rs, input logic [4:0] rt,
                       input logic u, input logic [4:0] d, input logic w, input logic m,
                       input logic fl);
    bus.id_valid     = v;
    bus.id_rs        = rs;
    bus.id_rt        = rt;
    bus.id_uses_rt   = u;
    bus.id_dst       = d;
    bus.id_reg_write = w;
    bus.id_mem_read  = m;
    bus.flush        = fl;
    #1;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    vec_cnt = 0;
    err_cnt = 0;
    rst_n   = 1'b0;
    issue(1'b0, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
    repeat (2) @(posedge clk);
    #2;
    check_val("rst_stall", 32'(bus.stall), 32'd0);
    check_val("rst_sel_a", 32'(bus.fwd_a_sel), 32'd0);
    check_val("rst_sel_b", 32'(bus.fwd_b_sel), 32'd0);
    check_val("rst_count", 32'(bus.stall_count), 32'd0);
    rst_n = 1'b1;
    tick();

    // distance 1: add $3,$1,$2 ; sub $4,$3,$5
    issue(1'b1, 5'd1, 5'd2, 1'b1, 5'd3, 1'b1, 1'b0, 1'b0); tick();
    issue(1'b1, 5'd3, 5'd5, 1'b1, 5'd4, 1'b1, 1'b0, 1'b0);
    check_val("d1_stall", 32'(bus.stall), 32'd0);
    tick();
    check_val("d1_sel_a", 32'(bus.fwd_a_sel), 32'd1);
    check_val("d1_sel_b", 32'(bus.fwd_b_sel), 32'd0);

    // distance 2: add $3 ; and $7,$8,$9 ; sub $4,$3,$5
    issue(1'b1, 5'd1, 5'd2, 1'b1, 5'd3, 1'b1, 1'b0, 1'b0); tick();
    issue(1'b1, 5'd8, 5'd9, 1'b1, 5'd7, 1'b1, 1'b0, 1'b0); tick();
    issue(1'b1, 5'd3, 5'd5, 1'b1, 5'd4, 1'b1, 1'b0, 1'b0); tick();
    check_val("d2_sel_a", 32'(bus.fwd_a_sel), 32'd2);
    check_val("d2_sel_b", 32'(bus.fwd_b_sel), 32'd0);

    // double hazard: add $3 ; add $3 ; or $6,$3,$3
    issue(1'b1, 5'd1, 5'd2, 1'b1, 5'd3, 1'b1, 1'b0, 1'b0); tick();
    issue(1'b1, 5'd1, 5'd2, 1'b1, 5'd3, 1'b1, 1'b0, 1'b0); tick();
    issue(1'b1, 5'd3, 5'd3, 1'b1, 5'd6, 1'b1, 1'b0, 1'b0); tick();
    check_val("dbl_sel_a", 32'(bus.fwd_a_sel), 32'd1);
    check_val("dbl_sel_b", 32'(bus.fwd_b_sel), 32'd1);

    // $0 never forwarded: add $0,$1,$2 ; or $6,$0,$0
    issue(1'b1, 5'd1, 5'd2, 1'b1, 5'd0, 1'b1, 1'b0, 1'b0); tick();
    issue(1'b1, 5'd0, 5'd0, 1'b1, 5'd6, 1'b1, 1'b0, 1'b0); tick();
    check_val("r0_sel_a", 32'(bus.fwd_a_sel), 32'd0);
    check_val("r0_sel_b", 32'(bus.fwd_b_sel), 32'd0);

    // load-use: lw $2,0($1) ; add $4,$2,$2
    issue(1'b1, 5'd1, 5'd2, 1'b0, 5'd2, 1'b1, 1'b1, 1'b0); tick();
    issue(1'b1, 5'd2, 5'd2, 1'b1, 5'd4, 1'b1, 1'b0, 1'b0);
    check_val("lu_stall1", 32'(bus.stall), 32'd1);
    tick();
    check_val("lu_bub_sel_a", 32'(bus.fwd_a_sel), 32'd0);
    check_val("lu_stall2", 32'(bus.stall), 32'd0);
    check_val("lu_count", 32'(bus.stall_count), 32'd1);
    tick();
    check_val("lu_sel_a", 32'(bus.fwd_a_sel), 32'd2);
    check_val("lu_sel_b", 32'(bus.fwd_b_sel), 32'd2);

    // rt not read: lw $2 ; addi $4,$5 with rt=$2
    issue(1'b1, 5'd1, 5'd2, 1'b0, 5'd2, 1'b1, 1'b1, 1'b0); tick();
    issue(1'b1, 5'd5, 5'd2, 1'b0, 5'd4, 1'b1, 1'b0, 1'b0);
    check_val("nort_stall", 32'(bus.stall), 32'd0);
    tick();
    check_val("nort_sel_a", 32'(bus.fwd_a_sel), 32'd0);
    check_val("nort_sel_b", 32'(bus.fwd_b_sel), 32'd0);
    check_val("nort_count", 32'(bus.stall_count), 32'd1);

    // flush over load-use
    issue(1'b1, 5'd1, 5'd2, 1'b0, 5'd2, 1'b1, 1'b1, 1'b0); tick();
    issue(1'b1, 5'd2, 5'd2, 1'b1, 5'd4, 1'b1, 1'b0, 1'b1);
    check_val("fl_stall", 32'(bus.stall), 32'd0);
    tick();
    check_val("fl_sel_a", 32'(bus.fwd_a_sel), 32'd0);
    check_val("fl_sel_b", 32'(bus.fwd_b_sel), 32'd0);
    check_val("fl_count", 32'(bus.stall_count), 32'd1);

    // flush kills a forward; the older add still advances to EX/MEM
    issue(1'b1, 5'd1, 5'd2, 1'b1, 5'd3, 1'b1, 1'b0, 1'b0); tick();
    issue(1'b1, 5'd3, 5'd5, 1'b1, 5'd4, 1'b1, 1'b0, 1'b1); tick();
    check_val("flf_sel_a", 32'(bus.fwd_a_sel), 32'd0);
    issue(1'b1, 5'd3, 5'd3, 1'b1, 5'd6, 1'b1, 1'b0, 1'b0); tick();
    check_val("flo_sel_a", 32'(bus.fwd_a_sel), 32'd2);
    check_val("flo_sel_b", 32'(bus.fwd_b_sel), 32'd2);

    // mid-stream reset: add $3 ; lw $2,0($3) ; add $4,$2,$2 then rst_n pulse
    issue(1'b1, 5'd1, 5'd2, 1'b1, 5'd3, 1'b1, 1'b0, 1'b0); tick();
    issue(1'b1, 5'd3, 5'd2, 1'b0, 5'd2, 1'b1, 1'b1, 1'b0); tick();
    check_val("pre_rst_sel_a", 32'(bus.fwd_a_sel), 32'd1);
    issue(1'b1, 5'd2, 5'd2, 1'b1, 5'd4, 1'b1, 1'b0, 1'b0);
    check_val("pre_rst_stall", 32'(bus.stall), 32'd1);
    rst_n = 1'b0;
    #1;
    check_val("mid_rst_stall", 32'(bus.stall), 32'd0);
    check_val("mid_rst_sel_a", 32'(bus.fwd_a_sel), 32'd0);
    check_val("mid_rst_count", 32'(bus.stall_count), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check_val("post_rst_stall", 32'(bus.stall), 32'd0);
    tick();
    check_val("post_rst_count", 32'(bus.stall_count), 32'd0);
    check_val("post_rst_sel_a", 32'(bus.fwd_a_sel), 32'd0);

    // saturation: 2^CNT_W + 3 load-use stalls
    for (int i = 0; i < (1 << CNT_W) + 3; i++) begin
      issue(1'b1, 5'd1, 5'd2, 1'b0, 5'd2, 1'b1, 1'b1, 1'b0); tick();
      issue(1'b1, 5'd2, 5'd2, 1'b1, 5'd4, 1'b1, 1'b0, 1'b0); tick();
      check_val($sformatf("sat_%0d", i), 32'(bus.stall_count),
                (i + 1 > 15) ? 32'd15 : 32'(i + 1));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule

// File: doc/forward_hazard_unit.md
Name: forward_hazard_unit

Overview:
Control end of the EX-stage operand forwarding path for the 5-stage MIPS pipeline. It generates the registered 2-bit select codes consumed by the 3:1 32-bit operand muxes: 00 selects the register-file operand, 01 selects the EX/MEM result and 10 selects the MEM/WB result. It keeps shadow copies of the ID/EX, EX/MEM and MEM/WB destination information. It also detects load-use hazards, requests a one-cycle stall, and counts stalls.

Parameters:
REG_AW, 5, register address width
CNT_W, 16, stall counter width

Ports:
clk  input  1  pipeline clock, rising edge
rst_n  input  1  asynchronous active-low reset
id_valid  input  1  ID stage holds a real instruction
id_rs  input  REG_AW  ID source register A
id_rt  input  REG_AW  ID source register B
id_uses_rt  input  1  instruction reads rt as an operand
id_dst  input  REG_AW  ID destination register
id_reg_write  input  1  ID instruction writes the register file
id_mem_read  input  1  ID instruction is a load
flush  input  1  branch/jump resolved taken; kill ID and ID/EX
stall  output  1  hold PC and IF/ID, insert bubble (combinational)
fwd_a_sel  output  2  EX operand A mux select (registered)
fwd_b_sel  output  2  EX operand B mux select (registered)
stall_count  output  CNT_W  saturating count of stall cycles

Behaviour:
- Reset (rst_n low, async): all three shadow entries invalid; fwd_a_sel = fwd_b_sel = 2'b00; stall_count = 0; stall = 0 while rst_n is low.
- Each shadow entry holds {valid, dst, reg_write, mem_read}. An entry "writes r" when valid & reg_write & dst == r & dst != 0.
- Stall (combinational) = id_valid & !flush & IDEX.valid & IDEX.mem_read & IDEX.reg_write & IDEX.dst != 0 & (IDEX.dst == id_rs | (id_uses_rt & IDEX.dst == id_rt)).
- Define kill = flush | stall | !id_valid.
- Every rising edge while rst_n is high:
  - MEMWB <= EXMEM.
  - EXMEM <= IDEX.
  - IDEX <= kill ? bubble (valid = 0) : ID fields.
- Select codes are computed in ID for the instruction entering EX and are registered:
  - fwd_a_sel <= kill ? 00 : (IDEX writes id_rs ? 01 : EXMEM writes id_rs ? 10 : 00).
  - fwd_b_sel is computed the same way using id_rt, forced to 00 when !id_uses_rt.
  - The registered selects are therefore aligned with the instruction in EX.
- Priority: the nearer producer (01) always beats the farther one (10).
- Register 0 is never forwarded.
- Code 11 is never driven.
- Load-use sequence:
  - The load sits in IDEX while the dependent instruction is in ID, so stall = 1 for exactly one cycle and a bubble enters IDEX.
  - On the next cycle the load is in EXMEM and stall = 0.
  - The dependent instruction then reaches EX with select 10 when the load is in MEMWB.
- The WB-to-ID same-cycle case belongs to the register file (write-first), not to this block.
- flush has priority over stall: stall is forced to 0, IDEX is loaded with a bubble, and both selects are set to 00. Older entries advance normally.
- stall_count increments by 1 on every edge where stall = 1. It saturates at all-ones and never wraps.
- Reset asserted mid-operation immediately clears all state. The first edge after release behaves as a fresh pipeline.

Test Plan:
- Dependency at distance 1 and 2:
  - add $3,$1,$2 then sub $4,$3,$5 -> fwd_a_sel = 01 in sub's EX cycle, no stall.
  - With one unrelated instruction between them -> fwd_a_sel = 10.
- Double hazard: add $3 / add $3 / or $6,$3,$3 -> fwd_a_sel = fwd_b_sel = 01 (nearest wins); $0 as destination or source -> selects 00.
- Load-use: lw $2,0($1) then add $4,$2,$2 -> stall = 1 for one cycle, bubble in IDEX, add's EX cycle shows fwd_a_sel = fwd_b_sel = 10, stall_count = 1.
- id_uses_rt = 0 with rt matching the load destination and rs not matching -> no stall, fwd_b_sel = 00.
- Flush while a load-use condition holds -> stall = 0, next-cycle selects 00, stall_count unchanged; mid-stream rst_n pulse -> selects 00 and stall_count = 0 asynchronously.
- Force 2^CNT_W + 3 stall cycles (CNT_W set to 4 in the bench) -> stall_count holds at 15.
